// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by memory_arbiter.
// The slave view belongs to the arbiter; the master view belongs to requesters and memory.
interface memory_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_width;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        mem_valid;
  logic        mem_we;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        resp_err;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_width, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output if_ready, if_rdata,
    output d_ready, d_rdata,
    output mem_valid, mem_we, mem_width, mem_addr, mem_wdata,
    output resp_err
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_width, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  if_ready, if_rdata,
    input  d_ready, d_rdata,
    input  mem_valid, mem_we, mem_width, mem_addr, mem_wdata,
    input  resp_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester (fetch / data) round-robin arbiter onto one memory port,
// with a per-transaction timeout that completes the request with resp_err.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  memory_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_d;
  logic             r_mem_valid;
  logic             r_mem_we;
  logic [2:0]       r_mem_width;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_if_ready;
  logic [31:0]      r_if_rdata;
  logic             r_d_ready;
  logic [31:0]      r_d_rdata;
  logic             r_resp_err;

  logic             w_grant_if;
  logic             w_grant_d;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic [31:0]      w_rdata;

  // On a tie the fetch side wins only when data was the last one served.
  assign w_grant_if = bus.if_req && (!bus.d_req || r_last_d);
  assign w_grant_d  = bus.d_req && !w_grant_if;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_timeout  = (w_cnt_inc >= CNT_W'(TIMEOUT));
  assign w_rdata    = r_mem_we ? 32'h0 : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last_d    <= 1'b1;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_width <= 3'b000;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_state     <= BUSY_IF;
            r_cnt       <= '0;
            r_last_d    <= 1'b0;
            r_mem_valid <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_width <= 3'b010;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= 32'h0;
          end else if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_cnt       <= '0;
            r_last_d    <= 1'b1;
            r_mem_valid <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_width <= bus.d_width;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
          end
        end

        BUSY_IF, BUSY_D: begin
          // A completion in the same cycle as the last allowed wait cycle still counts as success.
          if (bus.mem_ready || w_timeout) begin
            r_state     <= RESP;
            r_mem_valid <= 1'b0;
            r_resp_err  <= !bus.mem_ready;
            if (r_state == BUSY_IF) begin
              r_if_ready <= 1'b1;
              r_if_rdata <= bus.mem_ready ? w_rdata : 32'h0;
            end else begin
              r_d_ready  <= 1'b1;
              r_d_rdata  <= bus.mem_ready ? w_rdata : 32'h0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        RESP: begin
          r_state    <= IDLE;
          r_if_ready <= 1'b0;
          r_d_ready  <= 1'b0;
          r_resp_err <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_width = r_mem_width;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ready  = r_if_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.resp_err  = r_resp_err;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: one instance at the default timeout, one with TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  memory_arbiter_if a_bus ();
  memory_arbiter_if b_bus ();

  memory_arbiter u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_bus)
  );

  memory_arbiter #(.TIMEOUT(4)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Plays the memory for one transaction. Called on the falling edge of the cycle in which
  // the request is first presented; returns on the falling edge of the ready cycle.
  // lat counts cycles inclusively: request cycle through ready cycle.
  task automatic serve(input bit on_b, input int n_wait, input logic [31:0] rd,
                       output int n_valid, output int lat,
                       output logic [31:0] cap_addr, output logic [31:0] cap_wdata,
                       output logic cap_we, output logic [2:0] cap_width,
                       output int n_unstable);
    logic        vld;
    logic        rdy;
    logic [67:0] cur;
    n_valid = 0; lat = 1; n_unstable = 0; rdy = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0; cap_width = '0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      lat++;
      vld = on_b ? b_bus.mem_valid : a_bus.mem_valid;
      rdy = on_b ? (b_bus.if_ready | b_bus.d_ready) : (a_bus.if_ready | a_bus.d_ready);
      if (rdy) break;
      if (vld) begin
        n_valid++;
        cur = on_b ? {b_bus.mem_addr, b_bus.mem_wdata, b_bus.mem_we, b_bus.mem_width}
                   : {a_bus.mem_addr, a_bus.mem_wdata, a_bus.mem_we, a_bus.mem_width};
        if (n_valid == 1) {cap_addr, cap_wdata, cap_we, cap_width} = cur;
        else if (cur != {cap_addr, cap_wdata, cap_we, cap_width}) n_unstable++;
        if (on_b) begin
          b_bus.mem_ready = (n_valid > n_wait);
          b_bus.mem_rdata = rd;
        end else begin
          a_bus.mem_ready = (n_valid > n_wait);
          a_bus.mem_rdata = rd;
        end
      end
    end
    if (on_b) b_bus.mem_ready = 1'b0;
    else a_bus.mem_ready = 1'b0;
    check_eq("ready_seen", {31'h0, rdy}, 32'h1);
    $display("txn bus=%s addr=0x%08h we=%0d valid_cycles=%0d latency=%0d",
             on_b ? "B" : "A", cap_addr, cap_we, n_valid, lat);
  endtask

  int          nv, lat, nu, acc;
  logic [31:0] ca, cw;
  logic        cwe;
  logic [2:0]  cwd;

  initial begin
    a_bus.if_req = 0; a_bus.if_addr = 0; a_bus.d_req = 0; a_bus.d_we = 0; a_bus.d_width = 0;
    a_bus.d_addr = 0; a_bus.d_wdata = 0; a_bus.mem_ready = 0; a_bus.mem_rdata = 0;
    b_bus.if_req = 0; b_bus.if_addr = 0; b_bus.d_req = 0; b_bus.d_we = 0; b_bus.d_width = 0;
    b_bus.d_addr = 0; b_bus.d_wdata = 0; b_bus.mem_ready = 0; b_bus.mem_rdata = 0;
    rst_a = 1; rst_b = 1;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_mem_valid", {31'h0, a_bus.mem_valid}, 0);
    check_eq("rst_readys", {29'h0, a_bus.if_ready, a_bus.d_ready, a_bus.resp_err}, 0);
    check_eq("rst_mem_ctl", {28'h0, a_bus.mem_we, a_bus.mem_width}, 0);
    check_eq("rst_mem_addr", a_bus.mem_addr, 0);
    check_eq("rst_mem_wdata", a_bus.mem_wdata, 0);
    check_eq("rst_if_rdata", a_bus.if_rdata, 0);
    check_eq("rst_d_rdata", a_bus.d_rdata, 0);
    check_eq("rst_b_mem_valid", {31'h0, b_bus.mem_valid}, 0);
    rst_a = 0; rst_b = 0;
    @(negedge clk);

    // Tie from reset: fetch first, then data (write)
    a_bus.if_req = 1; a_bus.if_addr = 32'h40;
    a_bus.d_req = 1; a_bus.d_we = 1; a_bus.d_addr = 32'h200; a_bus.d_wdata = 32'hDEADBEEF;
    a_bus.d_width = 3'b010;
    serve(0, 0, 32'h11112222, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("tie1_if_ready", {31'h0, a_bus.if_ready}, 1);
    check_eq("tie1_d_ready", {31'h0, a_bus.d_ready}, 0);
    check_eq("tie1_if_rdata", a_bus.if_rdata, 32'h11112222);
    check_eq("tie1_addr", ca, 32'h40);
    check_eq("tie1_latency", lat, 3);
    @(negedge clk);
    a_bus.if_req = 0;
    check_eq("tie1_if_pulse_once", {31'h0, a_bus.if_ready}, 0);
    serve(0, 0, 32'h33334444, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("tie1_data_ready", {30'h0, a_bus.if_ready, a_bus.d_ready}, 32'h1);
    check_eq("tie1_data_addr", ca, 32'h200);
    check_eq("tie1_data_wdata", cw, 32'hDEADBEEF);
    check_eq("tie1_data_ctl", {28'h0, cwe, cwd}, {28'h0, 1'b1, 3'b010});
    check_eq("tie1_write_rdata", a_bus.d_rdata, 0);
    check_eq("tie1_if_rdata_hold", a_bus.if_rdata, 32'h11112222);
    @(negedge clk);
    a_bus.d_req = 0;

    // Repeat the tie: alternation holds
    a_bus.if_req = 1; a_bus.d_req = 1;
    serve(0, 0, 32'h55556666, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("tie2_first_fetch", {30'h0, a_bus.if_ready, a_bus.d_ready}, 32'h2);
    @(negedge clk);
    a_bus.if_req = 0;
    serve(0, 0, 32'h77778888, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("tie2_then_data", {30'h0, a_bus.if_ready, a_bus.d_ready}, 32'h1);
    @(negedge clk);
    a_bus.d_req = 0;

    // Single fetch
    a_bus.if_req = 1; a_bus.if_addr = 32'h100;
    serve(0, 0, 32'h00500093, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("fetch_addr", ca, 32'h100);
    check_eq("fetch_ctl", {28'h0, cwe, cwd}, {28'h0, 1'b0, 3'b010});
    check_eq("fetch_latency", lat, 3);
    check_eq("fetch_rdata", a_bus.if_rdata, 32'h00500093);
    check_eq("fetch_err", {31'h0, a_bus.resp_err}, 0);
    check_eq("fetch_valid_cycles", nv, 1);
    @(negedge clk);
    a_bus.if_req = 0;
    check_eq("fetch_rdata_hold", a_bus.if_rdata, 32'h00500093);

    // Memory wait: five stalled cycles, then completion
    a_bus.d_req = 1; a_bus.d_we = 0; a_bus.d_addr = 32'h300; a_bus.d_width = 3'b001;
    serve(0, 5, 32'h12345678, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("wait_valid_cycles", nv, 6);
    check_eq("wait_stable", nu, 0);
    check_eq("wait_d_ready", {30'h0, a_bus.if_ready, a_bus.d_ready}, 32'h1);
    check_eq("wait_d_rdata", a_bus.d_rdata, 32'h12345678);
    @(negedge clk);
    a_bus.d_req = 0;
    acc = 0;
    repeat (3) begin
      acc += int'(a_bus.d_ready) + int'(a_bus.if_ready);
      @(negedge clk);
    end
    check_eq("wait_single_pulse", acc, 0);

    // Stray strobe while idle
    a_bus.mem_ready = 1; a_bus.mem_rdata = 32'hFFFFFFFF;
    acc = 0;
    repeat (3) begin
      @(negedge clk);
      acc += int'(a_bus.mem_valid) + int'(a_bus.if_ready) + int'(a_bus.d_ready);
    end
    a_bus.mem_ready = 0;
    check_eq("stray_no_activity", acc, 0);
    check_eq("stray_d_rdata_hold", a_bus.d_rdata, 32'h12345678);

    // Reset in the second busy cycle of a fetch
    a_bus.if_req = 1; a_bus.if_addr = 32'h500;
    @(negedge clk);
    check_eq("rstmid_busy1", {31'h0, a_bus.mem_valid}, 1);
    @(negedge clk);
    check_eq("rstmid_busy2", {31'h0, a_bus.mem_valid}, 1);
    rst_a = 1; a_bus.if_req = 0;
    @(negedge clk);
    rst_a = 0;
    check_eq("rstmid_valid_drop", {31'h0, a_bus.mem_valid}, 0);
    check_eq("rstmid_addr_clear", a_bus.mem_addr, 0);
    acc = 0;
    repeat (4) begin
      acc += int'(a_bus.if_ready) + int'(a_bus.d_ready);
      @(negedge clk);
    end
    check_eq("rstmid_no_ready", acc, 0);
    a_bus.if_req = 1; a_bus.if_addr = 32'h600; a_bus.d_req = 1; a_bus.d_addr = 32'h700;
    serve(0, 0, 32'h0BADF00D, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("rstmid_tie_fetch", {30'h0, a_bus.if_ready, a_bus.d_ready}, 32'h2);
    @(negedge clk);
    a_bus.if_req = 0;
    serve(0, 0, 32'h00C0FFEE, nv, lat, ca, cw, cwe, cwd, nu);
    @(negedge clk);
    a_bus.d_req = 0;

    // Timeout on the TIMEOUT=4 instance, after a good read so rdata=0 is visible
    b_bus.d_req = 1; b_bus.d_we = 0; b_bus.d_addr = 32'h10; b_bus.d_width = 3'b010;
    serve(1, 0, 32'hA5A5A5A5, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("b_read_rdata", b_bus.d_rdata, 32'hA5A5A5A5);
    check_eq("b_read_err", {31'h0, b_bus.resp_err}, 0);
    @(negedge clk);
    b_bus.d_req = 0;
    b_bus.d_req = 1; b_bus.d_addr = 32'h20;
    serve(1, 100, 32'hCAFEF00D, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("to_valid_cycles", nv, 4);
    check_eq("to_d_ready", {30'h0, b_bus.if_ready, b_bus.d_ready}, 32'h1);
    check_eq("to_resp_err", {31'h0, b_bus.resp_err}, 1);
    check_eq("to_rdata_zero", b_bus.d_rdata, 0);
    check_eq("to_valid_drop", {31'h0, b_bus.mem_valid}, 0);
    @(negedge clk);
    b_bus.d_req = 0;
    check_eq("to_err_clear", {30'h0, b_bus.resp_err, b_bus.d_ready}, 0);
    b_bus.if_req = 1; b_bus.if_addr = 32'h30;
    serve(1, 0, 32'h00000077, nv, lat, ca, cw, cwe, cwd, nu);
    check_eq("to_back_idle", b_bus.if_rdata, 32'h00000077);
    check_eq("to_back_idle_lat", lat, 3);
    @(negedge clk);
    b_bus.if_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles waited for mem_ready before aborting a transaction.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-004 SHALL have ports if_req in 1 and if_addr in 32: the instruction-fetch request and its address.
REQ-005 SHALL have ports if_ready out 1 and if_rdata out 32: the fetch completion pulse and its data.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_width in 3, d_addr in 32 and d_wdata in 32: the data request, write enable, width code, address and write data.
REQ-007 SHALL have ports d_ready out 1 and d_rdata out 32: the data completion pulse and its data.
REQ-008 SHALL have ports mem_valid out 1, mem_we out 1, mem_width out 3, mem_addr out 32 and mem_wdata out 32: the shared memory port command.
REQ-009 SHALL have ports mem_ready in 1 and mem_rdata in 32: the memory completion strobe and its read data.
REQ-010 SHALL have port resp_err, out, 1, meaning the current if_ready or d_ready completion timed out.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D and RESP.
REQ-012 In IDLE with exactly one of if_req and d_req high, the FSM SHALL go to the matching BUSY state at the next edge.
REQ-013 In IDLE with both requests high, the FSM SHALL grant the requester not served last (round-robin); the last-served flag resets to "data", so fetch wins the first tie.
REQ-014 On grant, the arbiter SHALL register the winner's addr, we, width and wdata onto the mem_* outputs.
- For fetch: mem_we=0 and mem_width=3'b010.
- mem_* outputs SHALL stay stable until the transaction ends.
REQ-015 mem_valid SHALL be 1 exactly while in BUSY_IF or BUSY_D; the first mem_valid cycle is the cycle after the grant edge.
REQ-016 The arbiter SHALL treat a BUSY cycle with mem_ready=1 as completion.
- It captures mem_rdata (zero when mem_we=1).
- It enters RESP at the next edge.
REQ-017 In RESP, the arbiter SHALL pulse the served requester's ready for exactly one cycle, with its rdata valid in that cycle.
REQ-018 RESP SHALL always return to IDLE without sampling requests; a requester SHALL drop req after the edge ending its ready cycle.
REQ-019 if_rdata and d_rdata SHALL hold their last value outside RESP.
REQ-020 The non-served ready output SHALL stay 0.
REQ-021 Requests arriving while not in IDLE SHALL wait; the requester holds req and its signals stable until its ready pulse.
REQ-022 A 8-bit-or-wider timeout counter SHALL clear on grant and increment each BUSY cycle without mem_ready.
- When it reaches TIMEOUT, the FSM SHALL enter RESP with resp_err=1 and rdata=0.
- mem_valid drops in that RESP cycle.
REQ-023 resp_err SHALL be 0 in all cycles other than a timed-out RESP.
REQ-024 The minimum transaction latency SHALL be 3 cycles from req first seen in IDLE to ready, with mem_ready in the first mem_valid cycle.
REQ-025 mem_ready asserted outside BUSY SHALL be ignored.
REQ-026 The last-served flag SHALL update on every grant.

Reset
REQ-027 While rst=1 at an edge, the next state SHALL be:
- FSM in IDLE;
- mem_valid=0, if_ready=0, d_ready=0, resp_err=0;
- mem_we=0, mem_width=0, mem_addr=0, mem_wdata=0;
- if_rdata=0, d_rdata=0;
- timeout counter 0; last-served flag = data.
REQ-028 Reset during BUSY or RESP SHALL abort the transaction with no ready pulse; mem_valid is 0 from the cycle after the reset edge.

Verification
REQ-029 Single fetch: if_req, if_addr=0x100, mem_ready in the first mem_valid cycle with mem_rdata=0x00500093 -> mem_addr=0x100 and mem_we=0; if_ready pulses 3 cycles after req with if_rdata=0x00500093 and resp_err=0.
REQ-030 Tie: if_req and d_req high together from reset -> fetch served first, then data.
- Repeat the tie -> fetch again, then data (alternation holds).
- d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_width=3'b010 appear on mem_* during the data grant.
REQ-031 Memory wait: mem_ready held low for 5 BUSY cycles, then high with mem_rdata=0x12345678 -> mem_valid high for 6 cycles; d_ready pulses once with d_rdata=0x12345678.
REQ-032 Timeout: TIMEOUT=4 and mem_ready never asserted -> mem_valid high 4 cycles; ready pulses with resp_err=1 and rdata=0; FSM returns to IDLE.
REQ-033 Reset mid-transaction: rst=1 in the 2nd BUSY cycle -> mem_valid=0 the next cycle; no ready pulse; fetch wins the next tie.
REQ-034 Stray strobe: mem_ready=1 while IDLE -> no ready pulse and no state change.
